mp2_control: RTL and testbench

Multicycle RV32I control FSM that sits directly upstream of the MP2 datapath. It drives every mux select, register load and ALU/CMP opcode from the decoded instruction fields and branch result returned by the datapath. It also owns the memory read/write handshake and the store byte enables.

---
 rtl/ctrl_types.sv | 83 ++++++++
 rtl/ctrl_mem_watchdog.sv | 48 ++++
 rtl/mp2_control.sv | 207 ++++++++++++++++++++
 tb/tb_mp2_control.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_types.sv
// Shared types for the MP2 control FSM: datapath mux selects, RV32I encodings,
// FSM states, the opcode-to-state mapping and store byte-enable patterns.
package pcmux;
   typedef enum logic [1:0] {pc_plus4 = 2'b00, alu_out = 2'b01, alu_mod2 = 2'b10} pcmux_sel_t;
endpackage

package alumux;
   typedef enum logic {rs1_out = 1'b0, pc_out = 1'b1} alumux1_sel_t;
   typedef enum logic [2:0] {
      i_imm = 3'd0, u_imm = 3'd1, b_imm = 3'd2, s_imm = 3'd3, j_imm = 3'd4, rs2_out = 3'd5
   } alumux2_sel_t;
endpackage

package regfilemux;
   typedef enum logic [3:0] {
      alu_out = 4'd0, br_en = 4'd1, u_imm = 4'd2, lw = 4'd3, pc_plus4 = 4'd4,
      lb = 4'd5, lbu = 4'd6, lh = 4'd7, lhu = 4'd8
   } regfilemux_sel_t;
endpackage

package marmux;
   typedef enum logic {pc_out = 1'b0, alu_out = 1'b1} marmux_sel_t;
endpackage

package cmpmux;
   typedef enum logic {rs2_out = 1'b0, i_imm = 1'b1} cmpmux_sel_t;
endpackage

package ctrl_types;
   typedef enum logic [6:0] {
      op_lui   = 7'b0110111, op_auipc = 7'b0010111, op_jal   = 7'b1101111,
      op_jalr  = 7'b1100111, op_br    = 7'b1100011, op_load  = 7'b0000011,
      op_store = 7'b0100011, op_imm   = 7'b0010011, op_reg   = 7'b0110011,
      op_csr   = 7'b1110011
   } rv32i_opcode;

   typedef enum logic [2:0] {
      beq = 3'b000, bne = 3'b001, blt = 3'b100, bge = 3'b101, bltu = 3'b110, bgeu = 3'b111
   } branch_funct3_t;

   typedef enum logic [2:0] {
      lb = 3'b000, lh = 3'b001, lw = 3'b010, lbu = 3'b100, lhu = 3'b101
   } load_funct3_t;

   typedef enum logic [2:0] {sb = 3'b000, sh = 3'b001, sw = 3'b010} store_funct3_t;

   typedef enum logic [2:0] {
      add = 3'b000, sll = 3'b001, slt = 3'b010, sltu = 3'b011,
      axor = 3'b100, sr = 3'b101, aor = 3'b110, aand = 3'b111
   } arith_funct3_t;

   typedef enum logic [2:0] {
      alu_add = 3'b000, alu_sll = 3'b001, alu_sra = 3'b010, alu_sub = 3'b011,
      alu_xor = 3'b100, alu_srl = 3'b101, alu_or = 3'b110, alu_and = 3'b111
   } alu_ops;

   typedef enum logic [4:0] {
      s_fetch1, s_fetch2, s_fetch3, s_decode, s_imm, s_reg, s_lui, s_auipc, s_br,
      s_calc_addr, s_jal, s_jalr, s_ld1, s_ld2, s_st1, s_st2, s_halt
   } state_t;

   localparam logic [3:0] BE_WORD = 4'b1111;
   localparam logic [3:0] BE_HALF = 4'b0011;
   localparam logic [3:0] BE_BYTE = 4'b0001;

   // Unknown opcodes map to s_fetch1, which DECODE treats as an illegal instruction.
   function automatic state_t opcode_to_state(input logic [6:0] op);
      state_t s;
      s = s_fetch1;
      case (op)
         op_imm:            s = s_imm;
         op_reg:            s = s_reg;
         op_lui:            s = s_lui;
         op_auipc:          s = s_auipc;
         op_br:             s = s_br;
         op_load, op_store: s = s_calc_addr;
         op_jal:            s = s_jal;
         op_jalr:           s = s_jalr;
         default:           s = s_fetch1;
      endcase
      return s;
   endfunction
endpackage

// File: rtl/ctrl_mem_watchdog.sv
// Memory wait-state watchdog with sticky mem_err; CTRL_PERF_CNT_EN adds the
// retired-instruction and stall counters.
module ctrl_mem_watchdog #(
   parameter int WATCHDOG_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic in_wait,
   input  logic mem_resp,
   output logic timeout,
   output logic mem_err
`ifdef CTRL_PERF_CNT_EN
  ,input  logic        load_pc,
   output logic [31:0] perf_retired,
   output logic [31:0] perf_stall
`endif
);
   localparam int CW = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;

   logic          stall;
   logic [CW-1:0] wait_cnt;

   assign stall   = in_wait && !mem_resp;
   assign timeout = (WATCHDOG_CYCLES != 0) && stall && (wait_cnt == CW'(WATCHDOG_CYCLES - 1));

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!rst) begin
         wait_cnt <= '0;
         mem_err  <= 1'b0;
      end else begin
         wait_cnt <= stall ? wait_cnt + 1'b1 : '0;
         if (timeout) mem_err <= 1'b1;
      end
   end

`ifdef CTRL_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_retired <= '0;
         perf_stall   <= '0;
      end else begin
         if (load_pc) perf_retired <= perf_retired + 32'd1;
         if (stall)   perf_stall   <= perf_stall + 32'd1;
      end
   end
`endif
endmodule

// File: rtl/mp2_control.sv
// Multicycle RV32I control FSM driving the MP2 datapath selects, loads and memory
// handshake. Define CTRL_PERF_CNT_EN to add perf_retired/perf_stall outputs.
module mp2_control
   import ctrl_types::*;
#(
   parameter int WATCHDOG_CYCLES = 1024
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [6:0]                 opcode,
   input  logic [2:0]                 funct3,
   input  logic [6:0]                 funct7,
   input  logic                       br_en,
   input  logic [1:0]                 mem_addr_lo,
   input  logic                       mem_resp,
   output pcmux::pcmux_sel_t          pcmux_sel,
   output alumux::alumux1_sel_t       alumux1_sel,
   output alumux::alumux2_sel_t       alumux2_sel,
   output regfilemux::regfilemux_sel_t regfilemux_sel,
   output marmux::marmux_sel_t        marmux_sel,
   output cmpmux::cmpmux_sel_t        cmpmux_sel,
   output alu_ops                     aluop,
   output branch_funct3_t             cmpop,
   output logic                       load_pc,
   output logic                       load_ir,
   output logic                       load_regfile,
   output logic                       load_mar,
   output logic                       load_mdr,
   output logic                       load_data_out,
   output logic                       mem_read,
   output logic                       mem_write,
   output logic [3:0]                 mem_byte_enable,
   output logic                       illegal_insn,
   output logic                       mem_err
`ifdef CTRL_PERF_CNT_EN
  ,output logic [31:0]                perf_retired,
   output logic [31:0]                perf_stall
`endif
);
   state_t state_q, state_d;
   logic   in_wait, timeout, is_reg, unused_funct7;

   assign in_wait       = (state_q == s_fetch2) || (state_q == s_ld1) || (state_q == s_st1);
   assign is_reg        = (state_q == s_reg);
   assign unused_funct7 = ^{funct7[6], funct7[4:0]};

   ctrl_mem_watchdog #(.WATCHDOG_CYCLES(WATCHDOG_CYCLES)) u_watchdog (
      .clk          (clk),
      .rst          (rst),
      .in_wait      (in_wait),
      .mem_resp     (mem_resp),
      .timeout      (timeout),
      .mem_err      (mem_err)
`ifdef CTRL_PERF_CNT_EN
     ,.load_pc      (load_pc),
      .perf_retired (perf_retired),
      .perf_stall   (perf_stall)
`endif
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= s_fetch1;
      else      state_q <= state_d;
   end

   always_comb begin
      // NOTE: every output is defaulted first so no path through the case can infer a latch.
      state_d         = state_q;
      pcmux_sel       = pcmux::pc_plus4;
      alumux1_sel     = alumux::rs1_out;
      alumux2_sel     = alumux::i_imm;
      regfilemux_sel  = regfilemux::alu_out;
      marmux_sel      = marmux::pc_out;
      cmpmux_sel      = cmpmux::rs2_out;
      aluop           = alu_add;
      cmpop           = beq;
      load_pc         = 1'b0;
      load_ir         = 1'b0;
      load_regfile    = 1'b0;
      load_mar        = 1'b0;
      load_mdr        = 1'b0;
      load_data_out   = 1'b0;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      mem_byte_enable = BE_WORD;
      illegal_insn    = 1'b0;

      case (state_q)
         s_fetch1: begin
            marmux_sel = marmux::pc_out;
            load_mar   = 1'b1;
            state_d    = s_fetch2;
         end
         s_fetch2: begin
            mem_read = 1'b1;
            load_mdr = 1'b1;
            if (mem_resp) state_d = s_fetch3;
         end
         s_fetch3: begin
            load_ir = 1'b1;
            state_d = s_decode;
         end
         s_decode: begin
            state_d = opcode_to_state(opcode);
            if (state_d == s_fetch1) begin
               illegal_insn = 1'b1;
               load_pc      = 1'b1;
            end
         end
         s_imm, s_reg: begin
            load_regfile = 1'b1;
            load_pc      = 1'b1;
            aluop        = alu_ops'(funct3);
            if (is_reg) alumux2_sel = alumux::rs2_out;
            case (arith_funct3_t'(funct3))
               slt, sltu: begin
                  cmpop          = (funct3 == sltu) ? bltu : blt;
                  regfilemux_sel = regfilemux::br_en;
                  if (!is_reg) cmpmux_sel = cmpmux::i_imm;
               end
               sr:  if (funct7[5]) aluop = alu_sra;
               add: if (is_reg && funct7[5]) aluop = alu_sub;
               default: ;
            endcase
            state_d = s_fetch1;
         end
         s_lui: begin
            regfilemux_sel = regfilemux::u_imm;
            load_regfile   = 1'b1;
            load_pc        = 1'b1;
            state_d        = s_fetch1;
         end
         s_auipc: begin
            alumux1_sel  = alumux::pc_out;
            alumux2_sel  = alumux::u_imm;
            load_regfile = 1'b1;
            load_pc      = 1'b1;
            state_d      = s_fetch1;
         end
         s_br: begin
            cmpop       = branch_funct3_t'(funct3);
            alumux1_sel = alumux::pc_out;
            alumux2_sel = alumux::b_imm;
            pcmux_sel   = br_en ? pcmux::alu_out : pcmux::pc_plus4;
            load_pc     = 1'b1;
            state_d     = s_fetch1;
         end
         s_jal, s_jalr: begin
            regfilemux_sel = regfilemux::pc_plus4;
            load_regfile   = 1'b1;
            load_pc        = 1'b1;
            if (state_q == s_jal) begin
               alumux1_sel = alumux::pc_out;
               alumux2_sel = alumux::j_imm;
               pcmux_sel   = pcmux::alu_out;
            end else begin
               pcmux_sel   = pcmux::alu_mod2;
            end
            state_d = s_fetch1;
         end
         s_calc_addr: begin
            marmux_sel = marmux::alu_out;
            load_mar   = 1'b1;
            if (opcode == op_store) begin
               alumux2_sel   = alumux::s_imm;
               load_data_out = 1'b1;
               state_d       = s_st1;
            end else begin
               state_d       = s_ld1;
            end
         end
         s_ld1: begin
            mem_read = 1'b1;
            load_mdr = 1'b1;
            if (mem_resp) state_d = s_ld2;
         end
         s_ld2: begin
            case (load_funct3_t'(funct3))
               lb:      regfilemux_sel = regfilemux::lb;
               lh:      regfilemux_sel = regfilemux::lh;
               lbu:     regfilemux_sel = regfilemux::lbu;
               lhu:     regfilemux_sel = regfilemux::lhu;
               default: regfilemux_sel = regfilemux::lw;
            endcase
            load_regfile = 1'b1;
            load_pc      = 1'b1;
            state_d      = s_fetch1;
         end
         s_st1: begin
            mem_write = 1'b1;
            case (store_funct3_t'(funct3))
               sb:      mem_byte_enable = BE_BYTE << mem_addr_lo;
               sh:      mem_byte_enable = BE_HALF << {mem_addr_lo[1], 1'b0};
               default: mem_byte_enable = BE_WORD;
            endcase
            if (mem_resp) state_d = s_st2;
         end
         s_st2: begin
            load_pc = 1'b1;
            state_d = s_fetch1;
         end
         default: state_d = s_halt;
      endcase

      if (timeout) state_d = s_halt;
   end
endmodule

// File: tb/tb_mp2_control.sv
// Directed, table-driven bench for mp2_control: one record per instruction, plus
// hand-written watchdog/HALT and asynchronous-reset sequences.
module tb_mp2_control;
   import ctrl_types::*;

   logic clk = 1'b0;
   logic rst;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic br_en, mem_resp;
   logic [1:0] mem_addr_lo;
   pcmux::pcmux_sel_t pcmux_sel;
   alumux::alumux1_sel_t alumux1_sel;
   alumux::alumux2_sel_t alumux2_sel;
   regfilemux::regfilemux_sel_t regfilemux_sel;
   marmux::marmux_sel_t marmux_sel;
   cmpmux::cmpmux_sel_t cmpmux_sel;
   alu_ops aluop;
   branch_funct3_t cmpop;
   logic load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out;
   logic mem_read, mem_write, illegal_insn, mem_err;
   logic [3:0] mem_byte_enable;

   int total = 0;
   int bad = 0;

   mp2_control #(.WATCHDOG_CYCLES(8)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .br_en(br_en), .mem_addr_lo(mem_addr_lo), .mem_resp(mem_resp),
      .pcmux_sel(pcmux_sel), .alumux1_sel(alumux1_sel), .alumux2_sel(alumux2_sel),
      .regfilemux_sel(regfilemux_sel), .marmux_sel(marmux_sel), .cmpmux_sel(cmpmux_sel),
      .aluop(aluop), .cmpop(cmpop), .load_pc(load_pc), .load_ir(load_ir),
      .load_regfile(load_regfile), .load_mar(load_mar), .load_mdr(load_mdr),
      .load_data_out(load_data_out), .mem_read(mem_read), .mem_write(mem_write),
      .mem_byte_enable(mem_byte_enable), .illegal_insn(illegal_insn), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      string name;
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      logic br;
      logic [1:0] lo;
      int delay;
      int cycles;
      alu_ops aluop;
      alumux::alumux1_sel_t a1;
      alumux::alumux2_sel_t a2;
      cmpmux::cmpmux_sel_t cm;
      branch_funct3_t cmpop;
      regfilemux::regfilemux_sel_t rf;
      pcmux::pcmux_sel_t pc;
      logic ld_rf;
      logic [3:0] be;
      int rd_n;
      int wr_n;
      int ill_n;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Starts at a negedge in FETCH1, answers memory requests after v.delay wait
   // cycles, and snapshots the outputs on the cycle that loads the PC.
   task automatic run_insn(input vec_t v);
      int cyc = 0, rd_n = 0, wr_n = 0, ill_n = 0, wait_n = 0;
      logic done = 1'b0;
      logic [3:0] be_seen = 4'b1111;
      alu_ops s_aluop = alu_add;
      alumux::alumux1_sel_t s_a1 = alumux::rs1_out;
      alumux::alumux2_sel_t s_a2 = alumux::i_imm;
      cmpmux::cmpmux_sel_t s_cm = cmpmux::rs2_out;
      branch_funct3_t s_cmpop = beq;
      regfilemux::regfilemux_sel_t s_rf = regfilemux::alu_out;
      pcmux::pcmux_sel_t s_pc = pcmux::pc_plus4;
      logic s_ld_rf = 1'b0;
      opcode = v.op; funct3 = v.f3; funct7 = v.f7; br_en = v.br; mem_addr_lo = v.lo;
      check({v.name, ".start_fetch1"}, 32'(load_mar), 32'd1);
      while (!done && cyc < 64) begin
         cyc++;
         if (illegal_insn) ill_n++;
         if (mem_write) be_seen = mem_byte_enable;
         mem_resp = 1'b0;
         if (mem_read || mem_write) begin
            if (wait_n == v.delay) begin
               mem_resp = 1'b1;
               rd_n += int'(mem_read);
               wr_n += int'(mem_write);
               wait_n = 0;
            end else begin
               wait_n++;
            end
         end
         if (load_pc) begin
            done = 1'b1;
            s_aluop = aluop; s_a1 = alumux1_sel; s_a2 = alumux2_sel; s_cm = cmpmux_sel;
            s_cmpop = cmpop; s_rf = regfilemux_sel; s_pc = pcmux_sel; s_ld_rf = load_regfile;
         end
         @(negedge clk);
      end
      mem_resp = 1'b0;
      check({v.name, ".done"}, 32'(done), 32'd1);
      check({v.name, ".cycles"}, 32'(cyc), 32'(v.cycles));
      check({v.name, ".aluop"}, 32'(s_aluop), 32'(v.aluop));
      check({v.name, ".alumux1"}, 32'(s_a1), 32'(v.a1));
      check({v.name, ".alumux2"}, 32'(s_a2), 32'(v.a2));
      check({v.name, ".cmpmux"}, 32'(s_cm), 32'(v.cm));
      check({v.name, ".cmpop"}, 32'(s_cmpop), 32'(v.cmpop));
      check({v.name, ".regfilemux"}, 32'(s_rf), 32'(v.rf));
      check({v.name, ".pcmux"}, 32'(s_pc), 32'(v.pc));
      check({v.name, ".load_regfile"}, 32'(s_ld_rf), 32'(v.ld_rf));
      check({v.name, ".byte_enable"}, 32'(be_seen), 32'(v.be));
      check({v.name, ".reads"}, 32'(rd_n), 32'(v.rd_n));
      check({v.name, ".writes"}, 32'(wr_n), 32'(v.wr_n));
      check({v.name, ".illegal"}, 32'(ill_n), 32'(v.ill_n));
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int rd_cycles;
      // name op f3 f7 br lo delay cycles aluop a1 a2 cm cmpop rf pc ld_rf be rd wr ill
      vecs.push_back('{"addi", op_imm, 3'd0, 7'h00, 1'b0, 2'd0, 0, 5, alu_add, alumux::rs1_out, alumux::i_imm, cmpmux::rs2_out, beq, regfilemux::alu_out, pcmux::pc_plus4, 1'b1, 4'hf, 1, 0, 0});
      vecs.push_back('{"srai", op_imm, 3'd5, 7'h20, 1'b0, 2'd0, 0, 5, alu_sra, alumux::rs1_out, alumux::i_imm, cmpmux::rs2_out, beq, regfilemux::alu_out, pcmux::pc_plus4, 1'b1, 4'hf, 1, 0, 0});
      vecs.push_back('{"srli", op_imm, 3'd5, 7'h00, 1'b0, 2'd0, 0, 5, alu_srl, alumux::rs1_out, alumux::i_imm, cmpmux::rs2_out, beq, regfilemux::alu_out, pcmux::pc_plus4, 1'b1, 4'hf, 1, 0, 0});
      vecs.push_back('{"sltiu", op_imm, 3'd3, 7'h00, 1'b0, 2'd0, 0, 5, alu_ops'(3'b011), alumux::rs1_out, alumux::i_imm, cmpmux::i_imm, bltu, regfilemux::br_en, pcmux::pc_plus4, 1'b1, 4'hf, 1, 0, 0});
      vecs.push_back('{"add", op_reg, 3'd0, 7'h00, 1'b0, 2'd0, 0, 5, alu_add, alumux::rs1_out, alumux::rs2_out, cmpmux::rs2_out, beq, regfilemux::alu_out, pcmux::pc_plus4, 1'b1, 4'hf, 1, 0, 0});
      vecs.push_back('{"sub", op_reg, 3'd0, 7'h20, 1'b0, 2'd0, 0, 5, alu_sub, alumux::rs1_out, alumux::rs2_out, cmpmux::rs2_out, beq, regfilemux::alu_out, pcmux::pc_plus4, 1'b1, 4'hf, 1, 0, 0});
      vecs.push_back('{"sra", op_reg, 3'd5, 7'h20, 1'b0, 2'd0, 0, 5, alu_sra, alumux::rs1_out, alumux::rs2_out, cmpmux::rs2_out, beq, regfilemux::alu_out, pcmux::pc_plus4, 1'b1, 4'hf, 1, 0, 0});
      vecs.push_back('{"sltu", op_reg, 3'd3, 7'h00, 1'b0, 2'd0, 0, 5, alu_ops'(3'b011), alumux::rs1_out, alumux::rs2_out, cmpmux::rs2_out, bltu, regfilemux::br_en, pcmux::pc_plus4, 1'b1, 4'hf, 1, 0, 0});
      vecs.push_back('{"lui", op_lui, 3'd0, 7'h00, 1'b0, 2'd0, 0, 5, alu_add, alumux::rs1_out, alumux::i_imm, cmpmux::rs2_out, beq, regfilemux::u_imm, pcmux::pc_plus4, 1'b1, 4'hf, 1, 0, 0});
      vecs.push_back('{"auipc", op_auipc, 3'd0, 7'h00, 1'b0, 2'd0, 0, 5, alu_add, alumux::pc_out, alumux::u_imm, cmpmux::rs2_out, beq, regfilemux::alu_out, pcmux::pc_plus4, 1'b1, 4'hf, 1, 0, 0});
      vecs.push_back('{"beq_taken", op_br, 3'd0, 7'h00, 1'b1, 2'd0, 0, 5, alu_add, alumux::pc_out, alumux::b_imm, cmpmux::rs2_out, beq, regfilemux::alu_out, pcmux::alu_out, 1'b0, 4'hf, 1, 0, 0});
      vecs.push_back('{"beq_not", op_br, 3'd0, 7'h00, 1'b0, 2'd0, 0, 5, alu_add, alumux::pc_out, alumux::b_imm, cmpmux::rs2_out, beq, regfilemux::alu_out, pcmux::pc_plus4, 1'b0, 4'hf, 1, 0, 0});
      vecs.push_back('{"bltu_taken", op_br, 3'd6, 7'h00, 1'b1, 2'd0, 0, 5, alu_add, alumux::pc_out, alumux::b_imm, cmpmux::rs2_out, bltu, regfilemux::alu_out, pcmux::alu_out, 1'b0, 4'hf, 1, 0, 0});
      vecs.push_back('{"jal", op_jal, 3'd0, 7'h00, 1'b0, 2'd0, 0, 5, alu_add, alumux::pc_out, alumux::j_imm, cmpmux::rs2_out, beq, regfilemux::pc_plus4, pcmux::alu_out, 1'b1, 4'hf, 1, 0, 0});
      vecs.push_back('{"jalr", op_jalr, 3'd0, 7'h00, 1'b0, 2'd0, 0, 5, alu_add, alumux::rs1_out, alumux::i_imm, cmpmux::rs2_out, beq, regfilemux::pc_plus4, pcmux::alu_mod2, 1'b1, 4'hf, 1, 0, 0});
      vecs.push_back('{"lw", op_load, 3'd2, 7'h00, 1'b0, 2'd0, 0, 7, alu_add, alumux::rs1_out, alumux::i_imm, cmpmux::rs2_out, beq, regfilemux::lw, pcmux::pc_plus4, 1'b1, 4'hf, 2, 0, 0});
      vecs.push_back('{"lb", op_load, 3'd0, 7'h00, 1'b0, 2'd0, 0, 7, alu_add, alumux::rs1_out, alumux::i_imm, cmpmux::rs2_out, beq, regfilemux::lb, pcmux::pc_plus4, 1'b1, 4'hf, 2, 0, 0});
      vecs.push_back('{"lh", op_load, 3'd1, 7'h00, 1'b0, 2'd0, 0, 7, alu_add, alumux::rs1_out, alumux::i_imm, cmpmux::rs2_out, beq, regfilemux::lh, pcmux::pc_plus4, 1'b1, 4'hf, 2, 0, 0});
      vecs.push_back('{"lbu", op_load, 3'd4, 7'h00, 1'b0, 2'd0, 0, 7, alu_add, alumux::rs1_out, alumux::i_imm, cmpmux::rs2_out, beq, regfilemux::lbu, pcmux::pc_plus4, 1'b1, 4'hf, 2, 0, 0});
      vecs.push_back('{"lhu", op_load, 3'd5, 7'h00, 1'b0, 2'd0, 0, 7, alu_add, alumux::rs1_out, alumux::i_imm, cmpmux::rs2_out, beq, regfilemux::lhu, pcmux::pc_plus4, 1'b1, 4'hf, 2, 0, 0});
      vecs.push_back('{"sb_lo2", op_store, 3'd0, 7'h00, 1'b0, 2'd2, 0, 7, alu_add, alumux::rs1_out, alumux::i_imm, cmpmux::rs2_out, beq, regfilemux::alu_out, pcmux::pc_plus4, 1'b0, 4'b0100, 1, 1, 0});
      vecs.push_back('{"sb_lo3", op_store, 3'd0, 7'h00, 1'b0, 2'd3, 0, 7, alu_add, alumux::rs1_out, alumux::i_imm, cmpmux::rs2_out, beq, regfilemux::alu_out, pcmux::pc_plus4, 1'b0, 4'b1000, 1, 1, 0});
      vecs.push_back('{"sh_lo2", op_store, 3'd1, 7'h00, 1'b0, 2'd2, 0, 7, alu_add, alumux::rs1_out, alumux::i_imm, cmpmux::rs2_out, beq, regfilemux::alu_out, pcmux::pc_plus4, 1'b0, 4'b1100, 1, 1, 0});
      vecs.push_back('{"sh_lo0", op_store, 3'd1, 7'h00, 1'b0, 2'd0, 0, 7, alu_add, alumux::rs1_out, alumux::i_imm, cmpmux::rs2_out, beq, regfilemux::alu_out, pcmux::pc_plus4, 1'b0, 4'b0011, 1, 1, 0});
      vecs.push_back('{"sw", op_store, 3'd2, 7'h00, 1'b0, 2'd1, 0, 7, alu_add, alumux::rs1_out, alumux::i_imm, cmpmux::rs2_out, beq, regfilemux::alu_out, pcmux::pc_plus4, 1'b0, 4'b1111, 1, 1, 0});
      vecs.push_back('{"illegal", 7'h00, 3'd0, 7'h00, 1'b0, 2'd0, 0, 4, alu_add, alumux::rs1_out, alumux::i_imm, cmpmux::rs2_out, beq, regfilemux::alu_out, pcmux::pc_plus4, 1'b0, 4'hf, 1, 0, 1});
      vecs.push_back('{"lw_wait2", op_load, 3'd2, 7'h00, 1'b0, 2'd0, 2, 11, alu_add, alumux::rs1_out, alumux::i_imm, cmpmux::rs2_out, beq, regfilemux::lw, pcmux::pc_plus4, 1'b1, 4'hf, 2, 0, 0});
      vecs.push_back('{"addi_wait7", op_imm, 3'd0, 7'h00, 1'b0, 2'd0, 7, 12, alu_add, alumux::rs1_out, alumux::i_imm, cmpmux::rs2_out, beq, regfilemux::alu_out, pcmux::pc_plus4, 1'b1, 4'hf, 1, 0, 0});

      rst = 1'b0; opcode = 7'h00; funct3 = 3'd0; funct7 = 7'h00;
      br_en = 1'b0; mem_addr_lo = 2'd0; mem_resp = 1'b0;
      repeat (2) @(negedge clk);
      check("reset.load_mar", 32'(load_mar), 32'd1);
      check("reset.mem_read", 32'(mem_read), 32'd0);
      check("reset.mem_err", 32'(mem_err), 32'd0);
      rst = 1'b1;

      foreach (vecs[i]) run_insn(vecs[i]);
      check("no_spurious_mem_err", 32'(mem_err), 32'd0);

      // Withhold mem_resp in FETCH2 until the watchdog fires.
      opcode = op_imm;
      rd_cycles = 0;
      @(negedge clk);
      for (int i = 0; i < 20 && mem_read; i++) begin
         rd_cycles++;
         @(negedge clk);
      end
      check("wd.read_cycles", 32'(rd_cycles), 32'd8);
      check("wd.mem_err", 32'(mem_err), 32'd1);
      check("wd.mem_read", 32'(mem_read), 32'd0);
      check("wd.halt_load_mar", 32'(load_mar), 32'd0);
      mem_resp = 1'b1;
      @(negedge clk);
      mem_resp = 1'b0;
      repeat (2) @(negedge clk);
      check("halt.sticky_err", 32'(mem_err), 32'd1);
      check("halt.load_mar", 32'(load_mar), 32'd0);
      check("halt.mem_read", 32'(mem_read), 32'd0);
      check("halt.load_pc", 32'(load_pc), 32'd0);

      // Reset mid-cycle, before the next rising edge.
      #2 rst = 1'b0;
      #1;
      check("async_rst.load_mar", 32'(load_mar), 32'd1);
      check("async_rst.mem_err", 32'(mem_err), 32'd0);
      check("async_rst.mem_read", 32'(mem_read), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      run_insn(vecs[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
